control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Sequential front end directly upstream of the combinational control decoder.
- Owns the instruction register, the 4-bit step counter and the program counter, and selects the SRAM address each cycle.
- Consumes the decoder's rIR_enable, counter_clear, done and data_in_select strobes.
- Produces the rIR_data and counter values the decoder decodes, and guards against opcodes that never assert counter_clear.

Parameters:
ADDR_W, 16, width of program counter and SRAM address
RESET_VECTOR, 16'h0000, PC value after reset
MAX_STEP, 4'hF, counter value at which a non-terminating opcode is trapped

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
run  input  1  1 = advance; 0 = freeze all state (outputs hold)
data_in  input  8  SRAM/data bus byte
ad_addr  input  ADDR_W  {rAdH,rAdL} operand address from datapath
rIR_enable  input  1  decoder: load IR from data_in
counter_clear  input  1  decoder: step counter to 0
done  input  1  decoder: instruction completes this cycle
data_in_select  input  1  decoder: step consumes a data_in byte
rIR_data  output  8  instruction register to decoder
counter  output  4  step counter to decoder
pc  output  ADDR_W  program counter
addr_sel  output  1  1 = SRAM address from ad_addr, 0 = from pc
sram_addr  output  ADDR_W  addr_sel ? ad_addr : pc
illegal  output  1  sticky trap flag
retired  output  16  count of completed instructions

Behaviour:
- Clock and reset: single clock clk; resetn is asynchronous and active-low.
- Reset values (resetn low, async):
  - rIR_data=8'h00, counter=0, pc=RESET_VECTOR, illegal=0, retired=0.
  - Reset releases synchronously to clk.
  - With rIR_data=0 and counter=0 the decoder is in its fetch state, so the first opcode loads on the first run cycle.
- Freeze: when run=0, no register changes, regardless of the strobes.
- addr_sel (combinational): 1 iff rIR_data is 8'h3A (LDA) or 8'h32 (STA) and counter is 2 or 3; else 0.
- sram_addr: ad_addr when addr_sel=1, else pc.
- Step counter, priority order when run=1:
  1. Trap: counter==MAX_STEP and counter_clear=0.
     - Set illegal=1, rIR_data<=0, counter<=0, pc unchanged.
  2. counter_clear=1: counter<=0.
  3. Otherwise: counter<=counter+1.
  - counter never wraps: step 15 always resolves by clear or by trap.
- Instruction register (when run=1):
  - rIR_enable=1 and addr_sel=0: rIR_data<=data_in.
  - rIR_enable=1 and addr_sel=1: rIR_data<=8'h00 (fetch bubble). The bus held memory data, not an opcode, so the next cycle re-fetches at pc through the decoder's {IR=0,step 0} state.
  - Trap overrides both.
- Program counter (when run=1):
  - pc<=pc+1 (mod 2^ADDR_W, wraps all-ones to 0) iff (rIR_enable | data_in_select) & ~addr_sel & ~trap.
  - At most one increment per cycle, even if both strobes are high.
- retired: increments by 1 (mod 2^16) on each cycle with run=1 and done=1. A trap does not increment it.
- illegal: set only by trap; cleared only by resetn.
  - Execution continues after a trap by re-fetching from pc, so an illegal opcode costs 16 cycles and is skipped.
- Opcode 8'h00 (NOP/fetch):
  - Decoder asserts rIR_enable and counter_clear in step 0.
  - Sequencer loads the new opcode, counter stays 0, pc+1.
- Simultaneous rIR_enable, counter_clear and done in a final step:
  - IR loads, counter to 0, pc+1, retired+1, all in the same edge.
- Reset mid-instruction: everything returns to reset values immediately; no partial SRAM write is sequenced after resetn rises.

Test Plan:
- Reset with pc preset, assert resetn low mid-instruction with counter=2 -> counter=0, rIR_data=00, pc=0000, retired=0 asynchronously, before the next clk edge.
- Fetch 3E (MVI A) at 0000, operand 55, then 00 -> step0 pc 0001→0002, step1 IR<=next byte, pc=0003, retired=1, counter sequence 0,1,0.
- LDA 3A, 34, 12 from pc=0010 -> pc 0011→0012→0013; steps 2–3 addr_sel=1, sram_addr=ad_addr=1234; final rIR_enable loads 00 (bubble), pc stays 0013; next cycle fetches at 0013.
- Opcode FF with no strobes from decoder -> counter counts 0..15; at the edge after 15: illegal=1, rIR_data=00, counter=0, pc unchanged, retired unchanged.
- run=0 held 5 cycles mid-ADD (counter=1) with strobes toggling -> all outputs constant; resumes at counter=1→2.
- pc=FFFF, fetch opcode -> pc wraps to 0000; retired=FFFF plus one done -> 0000.

Source files
------------

// File: rtl/control_sequencer.sv
// Sequential front end for the control decoder: owns IR, step counter and PC,
// selects the SRAM address and traps opcodes that never clear the counter.
module control_sequencer #(
  parameter int unsigned         ADDR_W       = 16,
  parameter logic [ADDR_W-1:0]   RESET_VECTOR = '0,
  parameter logic [3:0]          MAX_STEP     = 4'hF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [7:0]        data_in,
  input  logic [ADDR_W-1:0] ad_addr,
  input  logic              rIR_enable,
  input  logic              counter_clear,
  input  logic              done,
  input  logic              data_in_select,
  output logic [7:0]        rIR_data,
  output logic [3:0]        counter,
  output logic [ADDR_W-1:0] pc,
  output logic              addr_sel,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              illegal,
  output logic [15:0]       retired
);

  localparam logic [7:0] OP_LDA = 8'h3A;
  localparam logic [7:0] OP_STA = 8'h32;

  typedef struct packed {
    logic [7:0]        ir;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] pc;
    logic              ill;
    logic [15:0]       ret;
  } seq_t;

  seq_t st_q, st_d;

  logic is_mem_op;
  logic mem_step;
  logic trap;
  logic pc_inc;

  assign is_mem_op = (st_q.ir == OP_LDA) || (st_q.ir == OP_STA);
  assign mem_step  = (st_q.cnt == 4'd2) || (st_q.cnt == 4'd3);
  assign addr_sel  = is_mem_op && mem_step;
  assign sram_addr = addr_sel ? ad_addr : st_q.pc;

  assign trap   = (st_q.cnt == MAX_STEP) && !counter_clear;
  assign pc_inc = (rIR_enable || data_in_select) && !addr_sel && !trap;

  always_comb begin
    st_d = st_q;
    if (run) begin
      if (trap) begin
        st_d.ill = 1'b1;
        st_d.ir  = 8'h00;
        st_d.cnt = 4'd0;
      end else begin
        st_d.cnt = counter_clear ? 4'd0 : st_q.cnt + 4'd1;
        // A load during a memory step saw operand data, not an opcode.
        if (rIR_enable) begin
          st_d.ir = addr_sel ? 8'h00 : data_in;
        end
        if (pc_inc) begin
          st_d.pc = st_q.pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        if (done) begin
          st_d.ret = st_q.ret + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q.ir  <= 8'h00;
      st_q.cnt <= 4'd0;
      st_q.pc  <= RESET_VECTOR;
      st_q.ill <= 1'b0;
      st_q.ret <= 16'd0;
    end else begin
      st_q <= st_d;
    end
  end

  assign rIR_data = st_q.ir;
  assign counter  = st_q.cnt;
  assign pc       = st_q.pc;
  assign illegal  = st_q.ill;
  assign retired  = st_q.ret;

endmodule
